// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side drain engine for the team's synchronous FIFO. It pops words
// through the FIFO's rinc/rempty/rdata port and absorbs the RAM's one-cycle
// read latency in a 3-entry prefetch buffer. The words are then presented as
// a valid/ready stream at up to one word per clock.
//
// The pop request depends only on registered state, rempty and reset. There
// is no combinational path from m_ready to fifo_rinc.
//
// Optional feature macro: FIFO_READER_LAST_EN
//   defined   : an 8-bit packet counter drives m_last on every PKT_LEN-th word
//   undefined : m_last is tied low and no counter is built
//
// Parameters
//   WIDTH    data width, must match the FIFO
//   PKT_LEN  words per packet for m_last (1..256)
//
// Ports
//   clk          in   single clock, shared with the FIFO
//   rst_n        in   synchronous active-low reset
//   fifo_rempty  in   FIFO empty flag
//   fifo_rinc    out  pop request to the FIFO
//   fifo_rdata   in   FIFO read data, valid the cycle after an honoured pop
//   m_valid      out  stream data valid
//   m_ready      in   downstream accept
//   m_data       out  stream data (0 while m_valid is low)
//   m_last       out  final word of a packet
//   buf_cnt      out  prefetch buffer occupancy, 0..3
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
   parameter int WIDTH   = 8,
   parameter int PKT_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_rempty,
   output logic             fifo_rinc,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [1:0]       buf_cnt
);

   if (PKT_LEN < 1 || PKT_LEN > 256) begin : g_bad_pkt_len
      $error("fifo_stream_reader: PKT_LEN must be in 1..256");
   end

   logic [WIDTH-1:0] buf_mem [3];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic             inflight;   // a pop was honoured last cycle; rdata is live
   logic             capture;
   logic             handshake;
   logic [2:0]       committed;  // buffered words plus the word in flight

   // Pointers walk 0,1,2,0,... over the three buffer entries.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Never ask for a word that might not fit. Every honoured pop already has
   // a free slot reserved, so the buffer cannot overflow.
   always_comb begin
      committed = {1'b0, buf_cnt} + {2'b00, inflight};
      fifo_rinc = rst_n && !fifo_rempty && (committed < 3'd3);
   end

   assign capture   = inflight;
   assign m_valid   = (buf_cnt != 2'd0);
   assign handshake = m_valid && m_ready;
   assign m_data    = m_valid ? buf_mem[rd_ptr] : '0;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, whatever the order of the blocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         buf_cnt  <= 2'd0;
         inflight <= 1'b0;
      end else begin
         // fifo_rinc already includes !fifo_rempty, so it marks an honoured pop.
         inflight <= fifo_rinc;
         if (capture)   wr_ptr <= ptr_inc(wr_ptr);
         if (handshake) rd_ptr <= ptr_inc(rd_ptr);
         // A capture and a handshake in the same cycle leave the count unchanged.
         case ({capture, handshake})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

   // NOTE: the buffer storage has no reset. An entry is only visible once it
   // is written and counted in buf_cnt, and m_data is forced to 0 while empty.
   always_ff @(posedge clk) begin
      if (rst_n && capture) begin
         buf_mem[wr_ptr] <= fifo_rdata;
      end
   end

`ifdef FIFO_READER_LAST_EN
   localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

   logic [7:0] pkt_cnt;   // position of the current head word within its packet

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt <= 8'd0;
      end else if (handshake) begin
         pkt_cnt <= (pkt_cnt == LAST_IDX) ? 8'd0 : pkt_cnt + 8'd1;
      end
   end

   assign m_last = m_valid && (pkt_cnt == LAST_IDX);
`else
   assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Self-checking bench for fifo_stream_reader. An upstream FIFO is modelled by
// a queue with one-cycle read latency. The reference keeps a list of the
// words popped but not yet delivered, plus an occupancy count that follows
// the reader's rules: a word lands one cycle after its pop, leaves on a
// handshake, and pops stop once buffered plus in-flight words reach 3.
// All inputs change 1 ns after the rising edge. Outputs are compared 1 ns
// later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

   localparam int WIDTH   = 8;
   localparam int PKT_LEN = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             fifo_rempty;
   logic             fifo_rinc;
   logic [WIDTH-1:0] fifo_rdata;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic [1:0]       buf_cnt;

   always #5 clk = ~clk;

   fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_rempty (fifo_rempty),
      .fifo_rinc   (fifo_rinc),
      .fifo_rdata  (fifo_rdata),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .buf_cnt     (buf_cnt)
   );

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [WIDTH-1:0] fifo_q [$];   // upstream FIFO contents
   logic [WIDTH-1:0] exp_q  [$];   // popped, not yet delivered, FIFO order
   int  m_cnt       = 0;           // words sitting in the prefetch buffer
   bit  inflight_m  = 1'b0;        // a pop was honoured last cycle
   int  pkt_pos     = 0;           // delivered words modulo PKT_LEN
   int  delivered   = 0;
   int  pops        = 0;
   int  last_cnt    = 0;           // handshakes where the DUT flagged m_last
   bit  valid_seen  = 1'b0;
   int  first_valid_cycle = 0;
   bit  hs_seen     = 1'b0;
   int  first_hs_cycle = 0;
   int  last_hs_cycle  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] word);
      fifo_q.push_back(word);
      fifo_rempty = 1'b0;
   endtask

   // Compare this cycle's outputs against the reference, then advance one clock.
   task automatic step();
      bit               exp_rinc;
      bit               exp_last;
      bit               pop;
      bit               hs;
      logic [WIDTH-1:0] word;
      #1;
      exp_rinc = rst_n && !fifo_rempty && ((m_cnt + int'(inflight_m)) < 3);
      chk("rinc", fifo_rinc, exp_rinc);
      chk("valid", m_valid, m_cnt != 0);
      chk("buf_cnt", buf_cnt, m_cnt);
      if (m_cnt != 0) chk("data", m_data, exp_q[0]);
      else if (!rst_n) chk("data_rst", m_data, 0);
`ifdef FIFO_READER_LAST_EN
      exp_last = (m_cnt != 0) && (pkt_pos == PKT_LEN - 1);
`else
      exp_last = 1'b0;
`endif
      chk("last", m_last, exp_last);

      pop = fifo_rinc && !fifo_rempty;
      hs  = (m_cnt != 0) && m_ready;
      if (hs && m_last === 1'b1) last_cnt++;
      if (!valid_seen && m_valid === 1'b1) begin
         valid_seen = 1'b1;
         first_valid_cycle = cycle;
      end
      if (hs) begin
         if (!hs_seen) begin
            hs_seen = 1'b1;
            first_hs_cycle = cycle;
         end
         last_hs_cycle = cycle;
      end

      @(posedge clk);
      #1;
      cycle++;
      if (!rst_n) begin
         // Reader and upstream FIFO share the reset.
         m_cnt      = 0;
         inflight_m = 1'b0;
         pkt_pos    = 0;
         exp_q.delete();
         fifo_q.delete();
         fifo_rdata = WIDTH'($urandom);
      end else begin
         m_cnt = m_cnt + int'(inflight_m) - int'(hs);
         if (hs) begin
            void'(exp_q.pop_front());
            delivered++;
            pkt_pos = (pkt_pos + 1) % PKT_LEN;
         end
         inflight_m = pop;
         if (pop) begin
            word = fifo_q.pop_front();
            exp_q.push_back(word);
            fifo_rdata = word;
            pops++;
         end else begin
            fifo_rdata = WIDTH'($urandom);
         end
      end
      fifo_rempty = (fifo_q.size() == 0);
   endtask

   task automatic clear_marks();
      valid_seen = 1'b0;
      hs_seen    = 1'b0;
      last_cnt   = 0;
   endtask

   initial begin
      int base;
      int start;
      int sent;
      int exp_last_cnt;

      rst_n       = 1'b0;
      fifo_rempty = 1'b1;
      fifo_rdata  = '0;
      m_ready     = 1'b0;
      @(posedge clk);
      #1;

      // Reset with an empty FIFO: two cycles held low.
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2) step();

      // Full-rate streaming of 0x01..0x08.
      m_ready = 1'b1;
      clear_marks();
      base = delivered;
      for (int i = 1; i <= 8; i++) push(WIDTH'(i));
      start = cycle;
      for (int i = 0; i < 40 && delivered < base + 8; i++) step();
      chk("stream_count", delivered - base, 8);
      chk("stream_latency", first_valid_cycle - start, 2);
      chk("stream_back_to_back", last_hs_cycle - first_hs_cycle, 7);
      repeat (2) step();

      // Backpressure: 8 words, m_ready low for 10 cycles.
      m_ready = 1'b0;
      base = delivered;
      start = pops;
      for (int i = 1; i <= 8; i++) push(WIDTH'(i));
      repeat (10) step();
      chk("bp_buf_cnt", buf_cnt, 3);
      chk("bp_pops", pops - start, 3);
      chk("bp_hold_data", m_data, 8'h01);
      m_ready = 1'b1;
      for (int i = 0; i < 40 && delivered < base + 8; i++) step();
      chk("bp_count", delivered - base, 8);
      repeat (2) step();

      // Packet marker: 8 words at full rate, starting on a packet boundary.
`ifdef FIFO_READER_LAST_EN
      exp_last_cnt = 2;
`else
      exp_last_cnt = 0;
`endif
      chk("pkt_aligned", pkt_pos, 0);
      clear_marks();
      base = delivered;
      for (int i = 0; i < 8; i++) push(WIDTH'(8'h21 + i));
      for (int i = 0; i < 40 && delivered < base + 8; i++) step();
      chk("pkt_count", delivered - base, 8);
      chk("pkt_last_cnt", last_cnt, exp_last_cnt);
      repeat (2) step();

      // Random m_ready and bursty upstream fill over 200 words.
      base = delivered;
      sent = 0;
      for (int i = 0; i < 4000 && delivered < base + 200; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         if (sent < 200 && $urandom_range(0, 99) < 45) begin
            for (int k = $urandom_range(1, 3); k > 0 && sent < 200; k--) begin
               push(WIDTH'($urandom));
               sent++;
            end
         end
         step();
      end
      chk("rand_count", delivered - base, 200);
      chk("rand_leftover", exp_q.size(), 0);
      m_ready = 1'b1;
      repeat (2) step();

      // Reset asserted the cycle after an honoured pop.
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(WIDTH'(8'hA0 + i));
      step();                      // pop honoured this cycle
      chk("mid_pop_seen", inflight_m, 1);
      rst_n = 1'b0;
      step();                      // returned word arrives during reset
      rst_n = 1'b1;
      chk("mid_valid", m_valid, 0);
      chk("mid_buf_cnt", buf_cnt, 0);
      chk("mid_data", m_data, 0);
      repeat (3) step();

      // Recovery after reset: packet count restarts from zero.
      m_ready = 1'b1;
      clear_marks();
      base = delivered;
      for (int i = 0; i < 4; i++) push(WIDTH'(8'h51 + i));
      for (int i = 0; i < 40 && delivered < base + 4; i++) step();
      chk("post_rst_count", delivered - base, 4);
      chk("post_rst_last", last_cnt, exp_last_cnt / 2);
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's synchronous FIFO. Pops words through the FIFO's `rinc`/`rempty`/`rdata` port, absorbs the RAM's one-cycle read latency in a 3-entry prefetch buffer, and presents them as a valid/ready stream.
- Sustains one word per clock.
- No combinational path from `m_ready` to `fifo_rinc`.

## Interface
Parameters:
- `WIDTH`, 8: data width; must match the FIFO.
- `PKT_LEN`, 4: words per packet for `m_last`. Range 1..256. Used only when `FIFO_READER_LAST_EN` is defined.

Ports:
- `clk`  in  1  single clock, shared with the FIFO.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fifo_rempty`  in  1  FIFO empty flag.
- `fifo_rinc`  out  1  pop request to the FIFO.
- `fifo_rdata`  in  WIDTH  FIFO read data, valid the cycle after an honoured pop.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  stream data.
- `m_last`  out  1  final word of a packet.
- `buf_cnt`  out  2  prefetch buffer occupancy, 0..3.

## Operation
- **Pop honoured:** a pop is honoured in cycle t iff `fifo_rinc`=1 and `fifo_rempty`=0.
- **In-flight flag:** set in cycle t+1 after an honoured pop. While set, `fifo_rdata` is written into the buffer tail.
- **Issue rule:** `fifo_rinc` = !`fifo_rempty` && (`buf_cnt` + `inflight` < 3).
  - Depends only on registered state and `fifo_rempty`.
  - This guarantees buffer overflow is impossible.
- **Buffer:** 3-entry circular buffer.
  - 2-bit write pointer and 2-bit read pointer, each wrapping 2→0.
  - `buf_cnt` is held in a register.
- **Stream output:**
  - `m_valid` = (`buf_cnt` != 0).
  - `m_data` = entry at the read pointer.
- **Handshake:** occurs when `m_valid` && `m_ready`. The read pointer advances and `buf_cnt` decrements.
- **Simultaneous capture and handshake:** `buf_cnt` is unchanged and both pointers advance.
- **Ordering:** words leave in FIFO order. None are dropped or duplicated.
- **Stalled output:** while `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable.
- **Reset** (any cycle, including with a pop in flight):
  - Pointers, `buf_cnt`, `inflight` and the packet counter clear.
  - A `fifo_rdata` word returned in the cycle after reset is discarded, because `inflight`=0.
  - The dropped word is lost by design. The upstream FIFO is reset on the same `rst_n`.

## Timing
- Reset values: `fifo_rinc`=0 (while `rst_n`=0), `m_valid`=0, `m_last`=0, `buf_cnt`=0, `m_data`=0.
- Latency from FIFO non-empty to stream:
  - Cycle t: `fifo_rempty` falls and `fifo_rinc`=1.
  - Cycle t+1: word captured.
  - Cycle t+2: `m_valid`=1.
- Steady state with `m_ready`=1 and the FIFO non-empty: `buf_cnt`=1, one pop and one handshake every cycle.
- Backpressure: with `m_ready`=0, `buf_cnt` saturates at 3 and `fifo_rinc` deasserts the cycle `buf_cnt` + `inflight` reaches 3.
- FIFO empties mid-stream: `fifo_rinc` drops the same cycle. Buffered words still drain.

## Configuration
- Macro: `FIFO_READER_LAST_EN`.
- Defined:
  - An 8-bit packet counter increments on each handshake and wraps to 0 after `PKT_LEN`-1.
  - `m_last` = `m_valid` && (counter == `PKT_LEN`-1).
- Undefined: `m_last` is tied to 0, and no counter is synthesised.

## Test plan
- **Reset, FIFO empty:** hold `rst_n`=0 for 2 cycles, `fifo_rempty`=1 → `fifo_rinc`=0, `m_valid`=0 and `buf_cnt`=0 for every cycle.
- **Streaming:** FIFO pre-loaded 0x01..0x08, `m_ready`=1 → `m_data` 0x01..0x08 on 8 consecutive cycles, first `m_valid` 2 cycles after `fifo_rempty` falls.
- **Backpressure:** 8 words, `m_ready`=0 for 10 cycles, then 1:
  - `buf_cnt` = 3 and exactly 3 pops issued.
  - `m_data` holds 0x01 during the stall.
  - All 8 words are then delivered in order.
- **Random `m_ready`:** 50% `m_ready` over 200 words → scoreboard shows no loss or duplication, and `buf_cnt` never exceeds 3.
- **Reset mid-burst:** assert reset the cycle after an honoured pop → `fifo_rdata` in the next cycle is ignored, `m_valid`=0 and `buf_cnt`=0 after reset.
- **Packet marker:** with `FIFO_READER_LAST_EN` and `PKT_LEN`=4, 8 words at full rate → `m_last`=1 only on words 4 and 8. With the macro undefined, `m_last` stays 0.
